// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with write bypass and busy scoreboard
module regfile_mp #(
  parameter  int XLEN     = 32,
  parameter  int DEPTH    = 32,
  parameter  int NREAD    = 2,
  parameter  int NWRITE   = 2,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic [NWRITE-1:0]      wr_en,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  output logic [DEPTH-1:0]       busy_vec
);

  logic [XLEN-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busyNext;
  logic [NWRITE-1:0] wrOk;

  logic [AW-1:0]   rdA   [NREAD];
  logic [NREAD-1:0] rdHit;
  logic [XLEN-1:0] rdFwd [NREAD];

  // Qualify write enables: writes to the hardwired zero register are dropped
  always_comb begin
    wrOk = '0;
    for (int j = 0; j < NWRITE; j++) begin
      wrOk[j] = wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0));
    end
  end

  // Storage update; later loop iterations override earlier ones so the highest port wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (wrOk[j]) begin
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Scoreboard next state: issue sets, writeback clears, issue beats writeback
  always_comb begin
    busyNext = '0;
    for (int r = 0; r < DEPTH; r++) begin
      logic setBit;
      logic clrBit;
      setBit = iss_en && (iss_addr == AW'(r));
      clrBit = 1'b0;
      for (int j = 0; j < NWRITE; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
          clrBit = 1'b1;
        end
      end
      busyNext[r] = setBit || (busy[r] && !clrBit);
    end
    if (ZERO_REG != 0) begin
      busyNext[0] = 1'b0;
    end
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

  assign busy_vec = busy;

  // Per read port: find the highest-index enabled write hitting the same address
  always_comb begin
    rdHit = '0;
    for (int i = 0; i < NREAD; i++) begin
      rdA[i]   = rd_addr[i*AW +: AW];
      rdFwd[i] = '0;
      for (int j = 0; j < NWRITE; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == rdA[i])) begin
          rdHit[i] = 1'b1;
          rdFwd[i] = wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Read data and busy outputs; zero register reads as 0 and never busy
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      logic isZero;
      logic issHit;
      isZero = (ZERO_REG != 0) && (rdA[i] == '0);
      issHit = iss_en && (iss_addr == rdA[i]);
      if (isZero) begin
        rd_data[i*XLEN +: XLEN] = '0;
        rd_busy[i]              = 1'b0;
      end else begin
        rd_data[i*XLEN +: XLEN] = ((BYPASS != 0) && rdHit[i]) ? rdFwd[i] : regs[rdA[i]];
        rd_busy[i]              = busy[rdA[i]] && !((BYPASS != 0) && rdHit[i] && !issHit);
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed-vector bench for regfile_mp, bypass and non-bypass instances
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rstN;
  logic [9:0]  rdAddr;
  logic [63:0] rdData, rdDataNb;
  logic [1:0]  rdBusy, rdBusyNb;
  logic [1:0]  wrEn;
  logic [9:0]  wrAddr;
  logic [63:0] wrData;
  logic        issEn;
  logic [4:0]  issAddr;
  logic [31:0] busyVec, busyVecNb;

  int nVec = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rstN), .rd_addr(rdAddr), .rd_data(rdData), .rd_busy(rdBusy),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .iss_en(issEn), .iss_addr(issAddr),
    .busy_vec(busyVec)
  );

  regfile_mp #(.BYPASS(0)) dutNb (
    .clk(clk), .rst_n(rstN), .rd_addr(rdAddr), .rd_data(rdDataNb), .rd_busy(rdBusyNb),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .iss_en(issEn), .iss_addr(issAddr),
    .busy_vec(busyVecNb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wrEn = 2'b00; issEn = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0; wrEn = 2'b11; wrAddr = {5'd5, 5'd5};
    wrData = {32'h0000_DEAD, 32'h0000_DEAD}; issEn = 1'b1; issAddr = 5'd5;
    rdAddr = {5'd5, 5'd5};
    step(); step();
    rstN = 1'b1; idle();
    #3;
    nVec++; if (rdData !== 64'h0) begin nMis++; $display("FAIL reset_rd: got %h want 0", rdData); end
    nVec++; if (rdDataNb !== 64'h0) begin nMis++; $display("FAIL reset_rd_nb: got %h want 0", rdDataNb); end
    nVec++; if (busyVec !== 32'h0) begin nMis++; $display("FAIL reset_busy: got %h want 0", busyVec); end
    nVec++; if (rdBusy !== 2'b00) begin nMis++; $display("FAIL reset_rdbusy: got %b want 00", rdBusy); end
    rdAddr = {5'd31, 5'd1};
    #1;
    nVec++; if (rdData !== 64'h0) begin nMis++; $display("FAIL reset_rd_other: got %h want 0", rdData); end
  endtask

  task automatic test_basic();
    step();
    wrEn = 2'b01; wrAddr = {5'd0, 5'd7}; wrData = {32'h0, 32'h1234_5678};
    rdAddr = {5'd0, 5'd7};
    #3;
    nVec++; if (rdData[31:0] !== 32'h1234_5678) begin nMis++; $display("FAIL basic_bypass: got %h want 12345678", rdData[31:0]); end
    nVec++; if (rdDataNb[31:0] !== 32'h0) begin nMis++; $display("FAIL basic_nobypass: got %h want 0", rdDataNb[31:0]); end
    step(); idle();
    #3;
    nVec++; if (rdData[31:0] !== 32'h1234_5678) begin nMis++; $display("FAIL basic_stored: got %h want 12345678", rdData[31:0]); end
    nVec++; if (rdDataNb[31:0] !== 32'h1234_5678) begin nMis++; $display("FAIL basic_stored_nb: got %h want 12345678", rdDataNb[31:0]); end
    nVec++; if (busyVec !== 32'h0) begin nMis++; $display("FAIL basic_nobusy: got %h want 0", busyVec); end
  endtask

  task automatic test_collision();
    step();
    wrEn = 2'b11; wrAddr = {5'd3, 5'd3}; wrData = {32'h5555_5555, 32'hAAAA_AAAA};
    rdAddr = {5'd3, 5'd3};
    #3;
    nVec++; if (rdData !== {32'h5555_5555, 32'h5555_5555}) begin nMis++; $display("FAIL coll_bypass: got %h want 5555555555555555", rdData); end
    nVec++; if (rdDataNb !== 64'h0) begin nMis++; $display("FAIL coll_nobypass: got %h want 0", rdDataNb); end
    step(); idle();
    #3;
    nVec++; if (rdDataNb[31:0] !== 32'h5555_5555) begin nMis++; $display("FAIL coll_stored: got %h want 55555555", rdDataNb[31:0]); end
    nVec++; if (rdData[63:32] !== 32'h5555_5555) begin nMis++; $display("FAIL coll_stored_p1: got %h want 55555555", rdData[63:32]); end
  endtask

  task automatic test_zero();
    step();
    wrEn = 2'b11; wrAddr = {5'd0, 5'd0}; wrData = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    issEn = 1'b1; issAddr = 5'd0; rdAddr = {5'd0, 5'd0};
    #3;
    nVec++; if (rdData !== 64'h0) begin nMis++; $display("FAIL zero_bypass: got %h want 0", rdData); end
    nVec++; if (rdBusy !== 2'b00) begin nMis++; $display("FAIL zero_rdbusy: got %b want 00", rdBusy); end
    step(); idle();
    #3;
    nVec++; if (rdDataNb !== 64'h0) begin nMis++; $display("FAIL zero_stored: got %h want 0", rdDataNb); end
    nVec++; if (busyVec[0] !== 1'b0) begin nMis++; $display("FAIL zero_busy: got %b want 0", busyVec[0]); end
  endtask

  task automatic test_scoreboard();
    step();
    issEn = 1'b1; issAddr = 5'd9; rdAddr = {5'd0, 5'd9};
    #3;
    nVec++; if (busyVec !== 32'h0) begin nMis++; $display("FAIL sb_pre: got %h want 0", busyVec); end
    step(); idle();
    #3;
    nVec++; if (busyVec !== 32'h0000_0200) begin nMis++; $display("FAIL sb_set: got %h want 00000200", busyVec); end
    nVec++; if (rdBusy[0] !== 1'b1) begin nMis++; $display("FAIL sb_rdbusy: got %b want 1", rdBusy[0]); end
    wrEn = 2'b01; wrAddr = {5'd0, 5'd9}; wrData = {32'h0, 32'h42};
    #1;
    nVec++; if (rdBusy[0] !== 1'b0) begin nMis++; $display("FAIL sb_wb_bypass: got %b want 0", rdBusy[0]); end
    nVec++; if (rdBusyNb[0] !== 1'b1) begin nMis++; $display("FAIL sb_wb_nobypass: got %b want 1", rdBusyNb[0]); end
    nVec++; if (rdData[31:0] !== 32'h42) begin nMis++; $display("FAIL sb_wb_data: got %h want 42", rdData[31:0]); end
    step(); idle();
    #3;
    nVec++; if (busyVec !== 32'h0) begin nMis++; $display("FAIL sb_clr: got %h want 0", busyVec); end
    nVec++; if (busyVecNb !== 32'h0) begin nMis++; $display("FAIL sb_clr_nb: got %h want 0", busyVecNb); end
    issEn = 1'b1; issAddr = 5'd9;
    step(); idle();
    #3;
    nVec++; if (busyVec[9] !== 1'b1) begin nMis++; $display("FAIL sb_reissue: got %b want 1", busyVec[9]); end
    issEn = 1'b1; issAddr = 5'd9;
    wrEn = 2'b01; wrAddr = {5'd0, 5'd9}; wrData = {32'h0, 32'h43};
    #1;
    nVec++; if (rdBusy[0] !== 1'b1) begin nMis++; $display("FAIL sb_iss_wb_rdbusy: got %b want 1", rdBusy[0]); end
    step(); idle();
    #3;
    nVec++; if (busyVec[9] !== 1'b1) begin nMis++; $display("FAIL sb_iss_beats_wb: got %b want 1", busyVec[9]); end
    nVec++; if (rdDataNb[31:0] !== 32'h43) begin nMis++; $display("FAIL sb_iss_wb_data: got %h want 43", rdDataNb[31:0]); end
  endtask

  task automatic test_midreset();
    step();
    wrEn = 2'b01; wrAddr = {5'd0, 5'd10}; wrData = {32'h0, 32'h77};
    step(); idle();
    issEn = 1'b1; issAddr = 5'd8;
    step(); issAddr = 5'd10;
    step(); issAddr = 5'd11;
    step(); idle();
    rdAddr = {5'd0, 5'd10};
    #3;
    nVec++; if (busyVec !== 32'h0000_0F00) begin nMis++; $display("FAIL mr_busy_pre: got %h want 00000f00", busyVec); end
    nVec++; if (rdData[31:0] !== 32'h77) begin nMis++; $display("FAIL mr_data_pre: got %h want 77", rdData[31:0]); end
    rstN = 1'b0; wrEn = 2'b01; wrData = {32'h0, 32'h99}; issEn = 1'b1; issAddr = 5'd12;
    step();
    rstN = 1'b1; idle();
    #3;
    nVec++; if (busyVec !== 32'h0) begin nMis++; $display("FAIL mr_busy: got %h want 0", busyVec); end
    nVec++; if (rdData[31:0] !== 32'h0) begin nMis++; $display("FAIL mr_data: got %h want 0", rdData[31:0]); end
    nVec++; if (rdDataNb !== 64'h0) begin nMis++; $display("FAIL mr_data_nb: got %h want 0", rdDataNb); end
    wrEn = 2'b01; wrData = {32'h0, 32'h1};
    step(); idle();
    #3;
    nVec++; if (rdDataNb[31:0] !== 32'h1) begin nMis++; $display("FAIL mr_post_write: got %h want 1", rdDataNb[31:0]); end
  endtask

  initial begin
    rstN = 1'b0; rdAddr = '0; wrEn = '0; wrAddr = '0; wrData = '0; issEn = 1'b0; issAddr = '0;
    test_reset();
    test_basic();
    test_collision();
    test_zero();
    test_scoreboard();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
